oipuf_64x4_top: RTL and testbench
=================================

# oipuf_64x4_top

Deterministic, clocked emulation of a 4-chain, 64-stage arbiter-style PUF. It exists for functional simulation and FPGA bring-up of the challenge/response datapath. A trigger launches one evaluation of the latched 64-bit challenge through TW linear additive-delay chains. The block reports per-chain response bits, their XOR, and per-chain stability flags derived from delay-difference margins.

## Interface
- TW, 4: number of parallel chains (response width).
- ST, 64: number of stages per chain (challenge width).
- THRESH, 64: minimum |delta| for a chain to be flagged stable.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- tigReg  in  1  evaluation trigger; a 0->1 transition starts an evaluation.
- iC  in  ST  challenge, captured on the start cycle.
- resp  out  TW  per-chain response bits.
- resp_xor  out  1  XOR of all resp bits.
- stable  out  1  AND of all stable_each bits.
- stable_each  out  TW  per-chain stability flags.
- valid  out  1  one-cycle pulse when results update.

## Operation
- Weights are fixed constants for chain k in 0..TW-1 and stage i in 0..ST-1:
  - w[k][i] = ((i+1)*(2k+3)*29 mod 255) - 127, a signed value in -127..127.
  - Bias b[k] = 8k - 12.
- Parity feature: phi[i] = product over j=i..ST-1 of (iC[j] ? -1 : +1).
- Delta: delta[k] = sum over i of w[k][i]*phi[i], plus b[k]. Held in a signed 16-bit accumulator; it cannot overflow for ST=64.
- Response: resp[k] = 1 iff delta[k] > 0. delta = 0 gives 0.
- Stability: stable_each[k] = 1 iff |delta[k]| >= THRESH.
- Combined outputs: resp_xor = ^resp and stable = &stable_each. Both are registered together with resp.
- Start condition: tigReg=1, registered previous tigReg=0, and block idle.
  - On start: latch iC, clear accumulators and the parity sign, set the stage index to ST-1, go busy.
- Busy phase: one stage per cycle, all chains in parallel, index ST-1 down to 0.
  - Each cycle: sign ^= iC[idx]; acc += sign ? -w : w.
- Finalize cycle: add the bias, update resp, resp_xor, stable_each and stable, pulse valid, return to idle.
- States: IDLE -> RUN (ST cycles) -> FINAL (1 cycle) -> IDLE.
- A trigger edge during RUN or FINAL is ignored. A new edge is needed after returning to IDLE.

## Timing
- Reset values: resp=0, resp_xor=0, stable=0, stable_each=0, valid=0. State is IDLE and the registered previous tigReg is 0.
- Because the previous-trigger register resets to 0, tigReg held high across reset release starts exactly one evaluation.
- Reset asserted mid-evaluation aborts it. Outputs return to reset values and no valid pulse occurs.
- Latency: valid asserts ST+1 cycles after the start edge. That is 65 cycles for ST=64.
- Outputs hold their last results until the next FINAL or reset.
- iC changes after the start cycle have no effect on the running evaluation.
- Back-to-back operation: the earliest next start is the cycle after FINAL. That gives a throughput of one evaluation per ST+2 cycles with a toggling trigger.

## Configuration
- OIPUF_STABILITY_EN defined:
  - The |delta| comparators are built.
  - stable_each and stable are as specified above.
- OIPUF_STABILITY_EN undefined:
  - The comparators are removed.
  - stable_each is forced to all ones and stable to 1 at the first FINAL after reset.
  - Both are 0 during and after reset until that FINAL.
  - resp, resp_xor and valid are unchanged.

## Test plan
- Reset: assert rst 2 cycles with tigReg=0 -> all outputs 0, valid stays 0 for 100 cycles.
- Basic evaluation: iC=64'h1444565890ABCDE1, raise tigReg and hold high -> valid pulses exactly once, 65 cycles after the start.
  - resp and stable_each match a bit-accurate golden model of the weight formula.
  - resp_xor = ^resp and stable = &stable_each.
- Parity corners:
  - iC=0 -> delta[k] equals the sum of w[k][i] plus b[k], matching the model.
  - iC=all ones -> alternating phi, matching the model.
  - Repeating each challenge gives identical outputs.
- Trigger protection: pulse tigReg 0->1->0->1 during RUN -> only one valid pulse. Changing iC mid-RUN does not alter the result.
- Abort: assert rst at cycle 30 of RUN -> no valid pulse, outputs 0. Then a new trigger completes normally in 65 cycles.
- Macro: build without OIPUF_STABILITY_EN, same challenge as the basic test -> identical resp, with stable_each=4'b1111 and stable=1 after FINAL.

Source files
------------

// File: rtl/oipuf_64x4_top.sv
// ---------------------------------------------------------------------------
// oipuf_64x4_top
// Deterministic clocked emulation of a TW-chain, ST-stage arbiter-style PUF.
// A rising edge on tigReg (while idle) latches the challenge and walks it
// through TW linear additive-delay chains, one stage per cycle from stage
// ST-1 down to 0. A final cycle adds the per-chain bias and registers the
// response and stability results together with a one-cycle valid pulse.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   tigReg       in   evaluation trigger (0->1 while idle starts a run)
//   iC[ST]       in   challenge, captured on the start cycle
//   resp[TW]     out  per-chain response bits (delta > 0)
//   resp_xor     out  XOR of all response bits
//   stable       out  AND of all per-chain stability flags
//   stable_each  out  per-chain flags, |delta| >= THRESH
//   valid        out  one-cycle pulse when the results update
//
// Configuration macro: OIPUF_STABILITY_EN
//   defined   : |delta| comparators are built and drive stable_each/stable.
//   undefined : comparators are removed; stable_each becomes all ones and
//               stable becomes 1 at the first FINAL after reset.
// ---------------------------------------------------------------------------
module oipuf_64x4_top #(
  parameter int TW     = 4,
  parameter int ST     = 64,
  parameter int THRESH = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tigReg,
  input  logic [ST-1:0] iC,
  output logic [TW-1:0] resp,
  output logic          resp_xor,
  output logic          stable,
  output logic [TW-1:0] stable_each,
  output logic          valid
);

  localparam int IW = (ST > 1) ? $clog2(ST) : 1;
  localparam logic signed [15:0] THR = 16'(THRESH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  // Stage weight: ((i+1)*(2k+3)*29 mod 255) - 127, range -127..127.
  function automatic logic signed [15:0] weight(input int k, input int i);
    int v;
    v = (((i + 1) * (2 * k + 3) * 29) % 255) - 127;
    return 16'(v);
  endfunction

  // Per-chain bias: 8k - 12.
  function automatic logic signed [15:0] bias(input int k);
    return 16'(8 * k - 12);
  endfunction

  // Margin check: a chain is stable when its delay difference is far from 0.
  function automatic logic is_stable(input logic signed [15:0] d);
    return (d >= THR) || (d <= -THR);
  endfunction

  state_t                r_state;
  state_t                w_next;
  logic                  r_tig_prev;
  logic [ST-1:0]         r_ch;
  logic [IW-1:0]         r_idx;
  logic                  r_sign;
  logic signed [15:0]    r_acc      [TW];
  logic signed [15:0]    w_acc_next [TW];
  logic signed [15:0]    w_delta    [TW];
  logic signed [15:0]    w_w        [TW][ST];
  logic signed [15:0]    w_step;
  logic                  w_sign_next;
  logic                  w_start;
  logic [TW-1:0]         w_resp;
  logic [TW-1:0]         w_stab;

  // Constant weight table, one entry per chain and stage.
  for (genvar gk = 0; gk < TW; gk++) begin : g_chain
    for (genvar gi = 0; gi < ST; gi++) begin : g_stage
      assign w_w[gk][gi] = weight(gk, gi);
    end
  end

  assign w_start = tigReg & ~r_tig_prev & (r_state == S_IDLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic: IDLE -> RUN (ST cycles) -> FINAL -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_RUN;
        else         w_next = S_IDLE;
      end
      S_RUN: begin
        if (r_idx == {IW{1'b0}}) w_next = S_FINAL;
        else                     w_next = S_RUN;
      end
      S_FINAL: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stage step and finalize arithmetic for all chains in parallel.
  // The running sign is the parity of iC[idx..ST-1]; odd parity means phi=-1.
  always_comb begin
    w_sign_next = r_sign ^ r_ch[r_idx];
    w_step      = 16'sd0;
    w_resp      = {TW{1'b0}};
    w_stab      = {TW{1'b0}};
    for (int k = 0; k < TW; k++) begin
      w_step        = w_sign_next ? -w_w[k][r_idx] : w_w[k][r_idx];
      w_acc_next[k] = r_acc[k] + w_step;
      w_delta[k]    = r_acc[k] + bias(k);
      w_resp[k]     = (w_delta[k] > 16'sd0);
`ifdef OIPUF_STABILITY_EN
      w_stab[k]     = is_stable(w_delta[k]);
`else
      w_stab[k]     = 1'b1;
`endif
    end
  end

  // Datapath and registered outputs: capture, accumulate, finalize.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tig_prev  <= 1'b0;
      r_ch        <= {ST{1'b0}};
      r_idx       <= {IW{1'b0}};
      r_sign      <= 1'b0;
      for (int k = 0; k < TW; k++) r_acc[k] <= 16'sd0;
      resp        <= {TW{1'b0}};
      resp_xor    <= 1'b0;
      stable      <= 1'b0;
      stable_each <= {TW{1'b0}};
      valid       <= 1'b0;
    end else begin
      r_tig_prev <= tigReg;
      valid      <= 1'b0;
      if (w_start) begin
        r_ch   <= iC;
        r_sign <= 1'b0;
        r_idx  <= IW'(ST - 1);
        for (int k = 0; k < TW; k++) r_acc[k] <= 16'sd0;
      end else if (r_state == S_RUN) begin
        r_sign <= w_sign_next;
        for (int k = 0; k < TW; k++) r_acc[k] <= w_acc_next[k];
        if (r_idx != {IW{1'b0}}) r_idx <= r_idx - IW'(1);
        else                     r_idx <= r_idx;
      end else if (r_state == S_FINAL) begin
        resp        <= w_resp;
        resp_xor    <= ^w_resp;
        stable_each <= w_stab;
        stable      <= &w_stab;
        valid       <= 1'b1;
      end else begin
        r_idx <= r_idx;
      end
    end
  end

endmodule

// File: tb/tb_oipuf_64x4_top.sv
// ---------------------------------------------------------------------------
// tb_oipuf_64x4_top
// Scoreboard bench for oipuf_64x4_top. Stimulus pushes the expected result
// (from a direct arithmetic model of the weight/parity formula) and its due
// cycle into a queue; a monitor pops and compares on every valid pulse.
// ---------------------------------------------------------------------------
module tb_oipuf_64x4_top;

  localparam int TW = 4;
  localparam int ST = 64;
  localparam int LAT = ST + 2; // from the drive cycle: start edge + ST + 1

  typedef struct {
    logic [TW-1:0] resp;
    logic [TW-1:0] stab;
    longint        due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tigReg = 1'b0;
  logic [ST-1:0] iC = '0;
  logic [TW-1:0] resp;
  logic          resp_xor;
  logic          stable;
  logic [TW-1:0] stable_each;
  logic          valid;

  int     tests = 0;
  int     fails = 0;
  int     vcount = 0;
  longint cyc = 0;
  exp_t   q[$];
  exp_t   last_e;

  oipuf_64x4_top #(.TW(TW), .ST(ST), .THRESH(64)) dut (
    .clk(clk), .rst(rst), .tigReg(tigReg), .iC(iC),
    .resp(resp), .resp_xor(resp_xor), .stable(stable),
    .stable_each(stable_each), .valid(valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Delay difference straight from the definition: phi[i] is a product of
  // signs over j=i..ST-1, weights from the closed-form expression.
  function automatic int model_delta(input int k, input logic [ST-1:0] c);
    int sum;
    int phi;
    int w;
    sum = 0;
    for (int i = 0; i < ST; i++) begin
      phi = 1;
      for (int j = i; j < ST; j++) if (c[j]) phi = -phi;
      w = (((i + 1) * (2 * k + 3) * 29) % 255) - 127;
      sum += w * phi;
    end
    return sum + 8 * k - 12;
  endfunction

  function automatic exp_t model(input logic [ST-1:0] c, input longint due);
    exp_t e;
    int d;
    for (int k = 0; k < TW; k++) begin
      d = model_delta(k, c);
      e.resp[k] = (d > 0);
`ifdef OIPUF_STABILITY_EN
      e.stab[k] = (d >= 64) || (d <= -64);
`else
      e.stab[k] = 1'b1;
`endif
    end
    e.due = due;
    return e;
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_valid: got valid=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency",     64'(cyc),         64'(e.due));
        chk("resp",        64'(resp),        64'(e.resp));
        chk("resp_xor",    64'(resp_xor),    64'(^e.resp));
        chk("stable_each", 64'(stable_each), 64'(e.stab));
        chk("stable",      64'(stable),      64'(&e.stab));
      end
    end
  end

  task automatic launch(input logic [ST-1:0] c);
    @(negedge clk);
    iC = c;
    tigReg = 1'b1;
    last_e = model(c, cyc + LAT);
    q.push_back(last_e);
  endtask

  task automatic wait_done(input int vbefore);
    for (int n = 0; n < 2 * LAT && q.size() != 0; n++) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
    chk("hold_resp",   64'(resp),        64'(last_e.resp));
    chk("hold_stab",   64'(stable_each), 64'(last_e.stab));
    chk("valid_count", 64'(vcount - vbefore), 64'd1);
    tigReg = 1'b0;
    @(negedge clk);
  endtask

  // Full evaluation; iC is scrambled mid-run to show it is not sampled again.
  task automatic run_eval(input logic [ST-1:0] c, input bit toggle);
    int vb;
    vb = vcount;
    launch(c);
    repeat (10) @(negedge clk);
    iC = {$urandom, $urandom};
    if (toggle) begin
      tigReg = 1'b0; @(negedge clk);
      tigReg = 1'b1; @(negedge clk);
      tigReg = 1'b0; @(negedge clk);
      tigReg = 1'b1;
    end
    wait_done(vb);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_resp"},        64'(resp),        64'd0);
    chk({tag, "_resp_xor"},    64'(resp_xor),    64'd0);
    chk({tag, "_stable"},      64'(stable),      64'd0);
    chk({tag, "_stable_each"}, 64'(stable_each), 64'd0);
    chk({tag, "_valid"},       64'(valid),       64'd0);
  endtask

  initial begin
    logic [ST-1:0] basic;
    logic [ST-1:0] c;
    int vb;
    basic = 64'h1444565890ABCDE1;

    // Reset for two cycles, then idle for 100 cycles with no pulse.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");
    vb = vcount;
    repeat (100) @(negedge clk);
    chk("idle_no_valid", 64'(vcount - vb), 64'd0);

    // Basic challenge and parity corners, each repeated.
    for (int r = 0; r < 2; r++) begin
      run_eval(basic, 1'b0);
      run_eval({ST{1'b0}}, 1'b0);
      run_eval({ST{1'b1}}, 1'b0);
    end

    // Trigger re-edges during RUN are ignored.
    run_eval(basic, 1'b1);

    // Random challenges.
    for (int r = 0; r < 6; r++) begin
      c = {$urandom, $urandom};
      run_eval(c, (r % 2) == 1);
    end

    // Back-to-back: restart on the cycle right after FINAL.
    vb = vcount;
    launch(basic);
    while (cyc < last_e.due - 1) @(negedge clk);
    tigReg = 1'b0;
    @(negedge clk);
    c = {$urandom, $urandom};
    iC = c;
    tigReg = 1'b1;
    last_e = model(c, cyc + LAT);
    q.push_back(last_e);
    for (int n = 0; n < 2 * LAT && q.size() != 0; n++) @(negedge clk);
    chk("b2b_pending", 64'(q.size()), 64'd0);
    q.delete();
    chk("b2b_valid_count", 64'(vcount - vb), 64'd2);
    tigReg = 1'b0;
    @(negedge clk);

    // Abort: reset at cycle 30 of RUN, no pulse, outputs cleared.
    vb = vcount;
    launch(basic);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    tigReg = 1'b0;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk_zero("abort");
    repeat (70) @(negedge clk);
    chk("abort_no_valid", 64'(vcount - vb), 64'd0);
    run_eval(basic, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
